dyn_scan_ctrl: RTL and testbench
================================

# dyn_scan_ctrl

Scan controller for the six-digit dynamic seven-segment display. It time-multiplexes the digits by stepping a digit index that drives the `sel` input of the downstream 6:1 nibble mux. It also produces the matching active-low digit-enable bus and a per-slot blanking window that suppresses ghosting. The mux output feeds the segment decoder, and `blank` gates the segment drivers during each slot change.

## Interface
Parameters:
- `DIV_CNT`, default 50000: clock cycles per digit slot (1 ms at 50 MHz). Legal range is at least 2.
- `BLANK_CNT`, default 500: cycles at the start of each slot during which all digits are off. Legal range is 0 to `DIV_CNT-1`.
- `DIGITS`, default 6: number of digits scanned. Legal range is 1 to 8.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: one clock; reset is asynchronous and active-high.
- `en`, input, 1: scan enable. When low, the display is dark and the scan is parked at digit 0.
- `sel`, output, 3: current digit index, 0 to `DIGITS-1`. Drives the mux select.
- `seg_sel`, output, `DIGITS`: active-low digit enables. Bit i low means digit i is lit.
- `blank`, output, 1: high while every digit is off. Use it to gate the segment drivers.
- `slot_tick`, output, 1: one-cycle pulse in the first cycle of each new slot.

## Operation
Registered state:
- `cnt` is the in-slot counter, width `$clog2(DIV_CNT)`.
- `sel` is the digit index.
- `seg_sel`, `blank` and `slot_tick` are output registers. There is no combinational path from any input to any output.

Reset values:
- `cnt`=0, `sel`=0, `blank`=1, `slot_tick`=0.
- `seg_sel` is all ones (6'h3F for the default `DIGITS`).
- Reset takes effect asynchronously at any point, including mid-slot or mid-blank.

States:
- IDLE: `en`=0 or reset.
  - `cnt` and `sel` are held at 0.
  - `seg_sel` is all ones, `blank`=1, `slot_tick`=0.
- SCAN: `en`=1.
  - `cnt` increments every cycle. It wraps from `DIV_CNT-1` to 0.
  - On that wrap, `sel` advances by one. It wraps from `DIGITS-1` to 0.
  - `slot_tick`=1 in the cycle after the wrap, i.e. when `cnt`=0 of a new slot.
- Transition IDLE to SCAN: on the first edge with `en`=1, `cnt` begins at 0 and `sel` at 0. The first slot does not produce `slot_tick`.
- Transition SCAN to IDLE: on the first edge with `en`=0, `cnt`, `sel` and `slot_tick` clear, and `seg_sel` and `blank` go dark. This happens regardless of the current slot position.

Output invariants, holding in every cycle after the register update, with the registered `cnt`/`sel` of that same cycle:
- `blank` is 1 exactly when `en` was 0 on the last edge, or when `cnt` < `BLANK_CNT`.
- `seg_sel` is all ones when `blank`=1. Otherwise it is `~(1 << sel)`, with exactly one bit low.
- `seg_sel` therefore never has two bits low, and it never changes directly from one lit digit to a different lit digit while `BLANK_CNT` > 0.

Degenerate parameter cases:
- `BLANK_CNT`=0: `blank` is never high during SCAN. The lit digit moves in the same cycle that `sel` changes.
- `DIGITS`=1: `sel` stays at 0. `slot_tick` still pulses every `DIV_CNT` cycles.

## Timing
- Slot length is exactly `DIV_CNT` cycles.
- Frame length is `DIGITS` × `DIV_CNT` cycles (6 ms at the defaults, giving about 167 Hz refresh).
- `sel` and `seg_sel` change on the same edge, so the mux select and the lit digit are always coherent. The downstream mux and decoder are combinational and add no cycles.
- The lit window per slot is `DIV_CNT`-`BLANK_CNT` cycles, starting at `cnt`=`BLANK_CNT`.
- Latency is one cycle from a change on `en` to a change on the outputs.
- `slot_tick` spacing is exactly `DIV_CNT` cycles while `en` stays high.

## Test plan
All scenarios use `DIV_CNT`=8, `BLANK_CNT`=2, `DIGITS`=6.
- **Reset:** assert `rst` mid-slot with `sel`=3 and `cnt`=5. Required response, asynchronously: `sel`=0, `seg_sel`=6'h3F, `blank`=1, `slot_tick`=0. Release with `en`=1: the first lit cycle is the 3rd edge after release, with `seg_sel`=6'b111110.
- **Full frame:** hold `en`=1 for 48 cycles. Required response:
  - `sel` steps 0→1→…→5→0 every 8 cycles.
  - Each slot shows 2 cycles of `seg_sel`=6'h3F, then 6 cycles of the single low bit `sel`.
  - `slot_tick` occurs 5 times; the first slot has none.
- **Enable drop:** drop `en` when `sel`=4 and `cnt`=6. Required response on the next edge: `sel`=0, `cnt`=0, `blank`=1, `seg_sel`=6'h3F. Re-raise `en`: the scan restarts at digit 0.
- **Wrap:** run two consecutive frames. Required response: `sel` goes 5→0 with `slot_tick`=1 at `cnt`=0, and `seg_sel` is 6'h3F for the first 2 cycles of the slot (no two-hot or adjacent-lit overlap).
- **Zero blanking:** set `BLANK_CNT`=0 and run a full frame. Required response: `blank` is never 1 during SCAN, and `seg_sel` goes 6'b111110→6'b111101 on the same edge that `sel` goes 0→1.
- **Invariant check:** run 1000 cycles of random `en` with a concurrent checker. Required response: `seg_sel` is always all ones or one-cold matching `sel`, and `blank` equals (`seg_sel` == all ones).

Source files
------------

// File: rtl/dyn_scan_ctrl.sv
// dyn_scan_ctrl: scan controller for a multiplexed seven-segment display.
// It steps a digit index for the nibble mux and drives the matching
// active-low digit enables. A short blanking window at the start of every
// slot keeps the previous digit from ghosting into the next one.
// All outputs are registered, so there is no input-to-output combinational path.

module dyn_scan_ctrl #(
   parameter int DIV_CNT   = 50000,
   parameter int BLANK_CNT = 500,
   parameter int DIGITS    = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [2:0]        sel,
   output logic [DIGITS-1:0] seg_sel,
   output logic              blank,
   output logic              slot_tick
);

   localparam int              CNT_W    = (DIV_CNT > 2) ? $clog2(DIV_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_CNT - 1);
   localparam logic [2:0]      SEL_MAX  = 3'(DIGITS - 1);
   localparam logic [DIGITS-1:0] DIGIT0 = DIGITS'(1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SCAN = 1'b1;

   logic [0:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_sel;
   logic [DIGITS-1:0] r_segSel;
   logic              r_blank;
   logic              r_slotTick;

   logic [0:0]        w_stateNext;
   logic [CNT_W-1:0]  w_cntNext;
   logic [2:0]        w_selNext;
   logic              w_wrap;
   logic              w_inBlank;
   logic              w_blankNext;
   logic [DIGITS-1:0] w_segSelNext;

   // Next slot position: park at digit 0 when disabled, restart cleanly on
   // the first enabled edge, otherwise count through the slot and advance
   // the digit on every counter wrap.
   always_comb begin
      w_stateNext = r_state;
      w_cntNext   = r_cnt;
      w_selNext   = r_sel;
      w_wrap      = 1'b0;
      if (!en) begin
         w_stateNext = ST_IDLE;
         w_cntNext   = '0;
         w_selNext   = 3'd0;
      end else if (r_state == ST_IDLE) begin
         w_stateNext = ST_SCAN;
         w_cntNext   = '0;
         w_selNext   = 3'd0;
      end else if (r_cnt == CNT_MAX) begin
         w_cntNext = '0;
         w_wrap    = 1'b1;
         w_selNext = (r_sel == SEL_MAX) ? 3'd0 : r_sel + 3'd1;
      end else begin
         w_cntNext = r_cnt + CNT_W'(1);
      end
   end

   // The blanking window compare disappears entirely when no blanking is wanted.
   if (BLANK_CNT == 0) begin : gNoBlank
      assign w_inBlank = 1'b0;
   end else begin : gBlank
      localparam logic [CNT_W-1:0] BLANK_W = CNT_W'(BLANK_CNT);
      assign w_inBlank = (w_cntNext < BLANK_W);
   end

   assign w_blankNext  = !en || w_inBlank;
   assign w_segSelNext = w_blankNext ? '1 : ~(DIGIT0 << w_selNext);

   // Register slot position and outputs together so the mux select and the
   // lit digit always change on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_sel      <= 3'd0;
         r_segSel   <= '1;
         r_blank    <= 1'b1;
         r_slotTick <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_cnt      <= w_cntNext;
         r_sel      <= w_selNext;
         r_segSel   <= w_segSelNext;
         r_blank    <= w_blankNext;
         r_slotTick <= w_wrap;
      end
   end

   assign sel       = r_sel;
   assign seg_sel   = r_segSel;
   assign blank     = r_blank;
   assign slot_tick = r_slotTick;

endmodule

// File: tb/tb_dyn_scan_ctrl.sv
// Testbench for dyn_scan_ctrl: a driver pushes expected outputs from a
// time-since-enable reference model into a scoreboard queue, a monitor pops
// and compares after every clock edge, and a concurrent checker watches the
// seg_sel/blank invariants. A second instance runs with no blanking.

module tb_dyn_scan_ctrl;

   localparam int DIV = 8;
   localparam int BLK = 2;
   localparam int DIG = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [2:0] sel, selZ;
   logic [5:0] segSel, segSelZ;
   logic       blank, blankZ, slotTick, slotTickZ;

   typedef struct {
      logic [2:0] sel;
      logic [5:0] seg;
      logic       blank;
      logic       tick;
      logic [5:0] segZ;
      logic       blankZ;
   } exp_t;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nPass   = 0;
   bit   mdlRun  = 1'b0;
   int   mdlT    = 0;
   bit   started = 1'b0;

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   dyn_scan_ctrl #(.DIV_CNT(DIV), .BLANK_CNT(BLK), .DIGITS(DIG)) dut (
      .clk(clk), .rst(rst), .en(en),
      .sel(sel), .seg_sel(segSel), .blank(blank), .slot_tick(slotTick)
   );

   dyn_scan_ctrl #(.DIV_CNT(DIV), .BLANK_CNT(0), .DIGITS(DIG)) dutZ (
      .clk(clk), .rst(rst), .en(en),
      .sel(selZ), .seg_sel(segSelZ), .blank(blankZ), .slot_tick(slotTickZ)
   );

   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got %0h, expected %0h at time %0t",
                    name, actual, expected, $time);
   endtask

   // Expected outputs from elapsed cycles since the scan started:
   // slot = t / DIV, digit = slot mod DIG, position in slot = t mod DIV.
   function automatic exp_t predict(input bit run, input int t);
      exp_t       e;
      int         pos;
      int         digit;
      logic [5:0] one;
      logic [5:0] lit;
      one   = 6'd1;
      pos   = t % DIV;
      digit = (t / DIV) % DIG;
      lit   = ~(one << digit);
      if (!run) begin
         e.sel = 3'd0; e.seg = 6'h3F; e.blank = 1'b1; e.tick = 1'b0;
         e.segZ = 6'h3F; e.blankZ = 1'b1;
      end else begin
         e.sel    = 3'(digit);
         e.blank  = (pos < BLK);
         e.seg    = e.blank ? 6'h3F : lit;
         e.tick   = (t > 0) && (pos == 0);
         e.segZ   = lit;
         e.blankZ = 1'b0;
      end
      return e;
   endfunction

   // Called at a negedge: drive en for the next edge, advance the model and
   // queue the response expected after that edge.
   task automatic applyStimulus(input logic enVal);
      en = enVal;
      if (enVal) begin
         if (mdlRun) mdlT++;
         else begin
            mdlRun = 1'b1;
            mdlT   = 0;
         end
      end else begin
         mdlRun = 1'b0;
      end
      expQ.push_back(predict(mdlRun, mdlT));
      @(negedge clk);
   endtask

   // Asynchronous reset between edges, checked before the next clock edge.
   task automatic applyReset();
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_sel",  8'(sel),      8'h00);
      checkOutput("rst_seg",  8'(segSel),   8'h3F);
      checkOutput("rst_blank", 8'(blank),   8'h01);
      checkOutput("rst_tick", 8'(slotTick), 8'h00);
      checkOutput("rst_segZ", 8'(segSelZ),  8'h3F);
      mdlRun = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: one expected entry per clock edge that was driven.
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("sel",    8'(sel),       8'(e.sel));
            checkOutput("seg",    8'(segSel),    8'(e.seg));
            checkOutput("blank",  8'(blank),     8'(e.blank));
            checkOutput("tick",   8'(slotTick),  8'(e.tick));
            checkOutput("selZ",   8'(selZ),      8'(e.sel));
            checkOutput("segZ",   8'(segSelZ),   8'(e.segZ));
            checkOutput("blankZ", 8'(blankZ),    8'(e.blankZ));
            checkOutput("tickZ",  8'(slotTickZ), 8'(e.tick));
         end
      end
   end

   // Concurrent invariant checker: dark or one-cold matching sel, and
   // blank tracks the all-dark condition, for both instances.
   always @(negedge clk) begin
      logic [5:0] one;
      one = 6'd1;
      if (started && !rst) begin
         checkOutput("inv_seg",   8'((segSel == 6'h3F) || (segSel == ~(one << sel))), 8'h01);
         checkOutput("inv_blank", 8'(blank), 8'(segSel == 6'h3F));
         checkOutput("inv_segZ",  8'((segSelZ == 6'h3F) || (segSelZ == ~(one << selZ))), 8'h01);
         checkOutput("inv_blankZ", 8'(blankZ), 8'(segSelZ == 6'h3F));
      end
   end

   // Watchdog so the run always ends.
   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      logic enR;
      #1 rst = 1'b1;
      #1;
      checkOutput("init_sel",   8'(sel),      8'h00);
      checkOutput("init_seg",   8'(segSel),   8'h3F);
      checkOutput("init_blank", 8'(blank),    8'h01);
      checkOutput("init_tick",  8'(slotTick), 8'h00);
      @(negedge clk);
      rst     = 1'b0;
      started = 1'b1;

      // Scan to sel=3, cnt=5, then reset mid-slot with en held high.
      for (int i = 0; i < 30; i++) applyStimulus(1'b1);
      applyReset();

      // Restart; run to sel=4, cnt=6 and drop en there.
      for (int i = 0; i < 39; i++) applyStimulus(1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0);

      // Two full frames plus a little, crossing the 5->0 wrap.
      for (int i = 0; i < 100; i++) applyStimulus(1'b1);

      // Random enable with long runs and occasional asynchronous resets.
      enR = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if ($urandom_range(0, 29) == 0) enR = ~enR;
         if ($urandom_range(0, 399) == 0) applyReset();
         applyStimulus(enR);
      end

      for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
      checkOutput("queue_drained", 8'(expQ.size()), 8'h00);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
